// File: rtl/datapath_scheduler.sv
// Round-robin scheduler sharing one 6-step evaluation datapath among NREQ requesters.
// Define DPS_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module datapath_scheduler #(
    parameter int NREQ = 4,
    parameter int DW   = 8
) (
    input  logic               clk,
    input  logic               RST,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] x_in,
    input  logic [DW-1:0]      dp_result,
    output logic [DW-1:0]      dp_x,
    output logic               LX,
    output logic               LS,
    output logic               LH,
    output logic               H,
    output logic [1:0]         M0,
    output logic [1:0]         M1,
    output logic [1:0]         M2,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    ack,
    output logic [DW-1:0]      result,
    output logic               busy
);

    localparam int PW = $clog2(NREQ);

    typedef enum logic [3:0] {
        ST_IDLE, ST_ARB, ST_LOAD, ST_S1, ST_S2, ST_S3, ST_S4, ST_WAIT, ST_DONE
    } state_e;

    typedef struct packed {
        logic       lx;
        logic       ls;
        logic       lh;
        logic       h;
        logic [1:0] m0;
        logic [1:0] m1;
        logic [1:0] m2;
    } ctrl_t;

    state_e          state_q, state_d;
    ctrl_t           ctrl_q, ctrl_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [DW-1:0]   dp_x_q, dp_x_d;
    logic [DW-1:0]   result_q, result_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            busy_q, busy_d;

    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic [NREQ-1:0] win_onehot;

    function automatic logic [PW-1:0] search_idx(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return PW'(s);
    endfunction

    // Winner search: rotating start point, or always from index 0 in fixed-priority builds.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
`ifdef DPS_FIXED_PRIO_EN
            if (!win_found && req[i]) begin
                win_found = 1'b1;
                win_idx   = PW'(i);
            end
`else
            if (!win_found && req[search_idx(rr_ptr_q, i)]) begin
                win_found = 1'b1;
                win_idx   = search_idx(rr_ptr_q, i);
            end
`endif
        end
        win_onehot[win_idx] = win_found;
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        dp_x_d   = dp_x_q;
        result_d = result_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: if (|req) state_d = ST_ARB;
            ST_ARB: begin
                if (win_found) begin
                    gnt_d   = win_onehot;
                    dp_x_d  = x_in[int'(win_idx)*DW +: DW];
                    state_d = ST_LOAD;
`ifdef DPS_FIXED_PRIO_EN
                    rr_ptr_d = '0;
`else
                    rr_ptr_d = (int'(win_idx) == NREQ-1) ? '0 : win_idx + PW'(1);
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: state_d = ST_S1;
            ST_S1:   state_d = ST_S2;
            ST_S2:   state_d = ST_S3;
            ST_S3:   state_d = ST_S4;
            ST_S4:   state_d = ST_WAIT;
            ST_WAIT: begin
                result_d = dp_result;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                gnt_d   = '0;
                state_d = |(req & ~gnt_q) ? ST_ARB : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore outputs are decoded from the next state so they register alongside it.
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            ST_LOAD: begin ctrl_d.lx = 1'b1; ctrl_d.h = 1'b1; ctrl_d.m1 = 2'b01; end
            ST_S1: begin
                ctrl_d.lh = 1'b1; ctrl_d.h = 1'b1; ctrl_d.m0 = 2'b01; ctrl_d.m2 = 2'b11;
            end
            ST_S2: begin ctrl_d.lh = 1'b1; ctrl_d.h = 1'b1; ctrl_d.m0 = 2'b10; end
            ST_S3: begin
                ctrl_d.ls = 1'b1; ctrl_d.m0 = 2'b10; ctrl_d.m1 = 2'b10; ctrl_d.m2 = 2'b11;
            end
            ST_S4, ST_WAIT: begin ctrl_d.ls = 1'b1; ctrl_d.m0 = 2'b11; ctrl_d.m2 = 2'b10; end
            default: ctrl_d = '0;
        endcase
        busy_d = (state_d != ST_IDLE);
        ack_d  = (state_d == ST_DONE) ? gnt_q : '0;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= '0;
            gnt_q    <= '0;
            ack_q    <= '0;
            dp_x_q   <= '0;
            result_q <= '0;
            rr_ptr_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            dp_x_q   <= dp_x_d;
            result_q <= result_d;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= busy_d;
        end
    end

    assign dp_x   = dp_x_q;
    assign LX     = ctrl_q.lx;
    assign LS     = ctrl_q.ls;
    assign LH     = ctrl_q.lh;
    assign H      = ctrl_q.h;
    assign M0     = ctrl_q.m0;
    assign M1     = ctrl_q.m1;
    assign M2     = ctrl_q.m2;
    assign gnt    = gnt_q;
    assign ack    = ack_q;
    assign result = result_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_datapath_scheduler.sv
// Directed bench for datapath_scheduler: control table, reset abort, round-robin order, corners.
module tb_datapath_scheduler;

    localparam int NREQ = 4;
    localparam int DW   = 8;

    logic               clk;
    logic               RST;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] x_in;
    logic [DW-1:0]      dp_result;
    logic [DW-1:0]      dp_x;
    logic               LX, LS, LH, H;
    logic [1:0]         M0, M1, M2;
    logic [NREQ-1:0]    gnt, ack;
    logic [DW-1:0]      result;
    logic               busy;
    logic [9:0]         ctrl;

    int checks = 0;
    int errors = 0;

    datapath_scheduler #(.NREQ(NREQ), .DW(DW)) dut (
        .clk(clk), .RST(RST), .req(req), .x_in(x_in), .dp_result(dp_result),
        .dp_x(dp_x), .LX(LX), .LS(LS), .LH(LH), .H(H), .M0(M0), .M1(M1), .M2(M2),
        .gnt(gnt), .ack(ack), .result(result), .busy(busy)
    );

    assign ctrl = {LX, LS, LH, H, M0, M1, M2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            busy;
        logic [NREQ-1:0] gnt;
        logic [NREQ-1:0] ack;
        logic [9:0]      ctrl;
        logic            dpx_vld;
        logic [DW-1:0]   dp_x;
        logic [DW-1:0]   result;
    } vec_t;

    function automatic logic [9:0] mk(input logic lx, input logic ls, input logic lh,
                                      input logic h, input logic [1:0] m0,
                                      input logic [1:0] m1, input logic [1:0] m2);
        return {lx, ls, lh, h, m0, m1, m2};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        RST = 1'b0;
        cyc();
        cyc();
        RST = 1'b1;
    endtask

    vec_t            tbl[9];
    logic [NREQ-1:0] gseq[4];
    int              gcyc[4];
    int              ng, nack, gaps;
    logic [NREQ-1:0] prev_gnt;
    logic [9:0]      s4;

    initial begin
        req       = '0;
        x_in      = '0;
        dp_result = '0;
        RST       = 1'b0;
        @(negedge clk);
        do_reset();

        // Reset mid-S2 aborts the op with everything cleared and no ack.
        x_in[0*DW +: DW] = 8'h11;
        req = 4'b0001;
        for (int e = 0; e < 4; e++) cyc();
        check("rst_pre_s2_lh", {31'd0, LH}, 32'd1);
        check("rst_pre_dpx", {24'd0, dp_x}, 32'h11);
        RST = 1'b0;
        #1;
        check("rst_ctrl", {22'd0, ctrl}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_gnt", {28'd0, gnt}, 32'd0);
        check("rst_ack", {28'd0, ack}, 32'd0);
        check("rst_dpx", {24'd0, dp_x}, 32'd0);
        check("rst_result", {24'd0, result}, 32'd0);
        req = '0;
        cyc();
        cyc();
        RST = 1'b1;
        for (int e = 0; e < 3; e++) begin
            cyc();
            check("rst_idle_busy", {31'd0, busy}, 32'd0);
            check("rst_idle_ack", {28'd0, ack}, 32'd0);
        end

        // Single op on requester 1: full per-state table after edges E0..E8.
        s4 = mk(0, 1, 0, 0, 2'b11, 2'b00, 2'b10);
        tbl[0] = '{1'b1, 4'b0000, 4'b0000, 10'd0, 1'b1, 8'h00, 8'h00};
        tbl[1] = '{1'b1, 4'b0010, 4'b0000, mk(1, 0, 0, 1, 2'b00, 2'b01, 2'b00), 1'b1, 8'h05, 8'h00};
        tbl[2] = '{1'b1, 4'b0010, 4'b0000, mk(0, 0, 1, 1, 2'b01, 2'b00, 2'b11), 1'b1, 8'h05, 8'h00};
        tbl[3] = '{1'b1, 4'b0010, 4'b0000, mk(0, 0, 1, 1, 2'b10, 2'b00, 2'b00), 1'b1, 8'h05, 8'h00};
        tbl[4] = '{1'b1, 4'b0010, 4'b0000, mk(0, 1, 0, 0, 2'b10, 2'b10, 2'b11), 1'b1, 8'h05, 8'h00};
        tbl[5] = '{1'b1, 4'b0010, 4'b0000, s4, 1'b1, 8'h05, 8'h00};
        tbl[6] = '{1'b1, 4'b0010, 4'b0000, s4, 1'b1, 8'h05, 8'h00};
        tbl[7] = '{1'b1, 4'b0010, 4'b0010, 10'd0, 1'b1, 8'h05, 8'h3C};
        tbl[8] = '{1'b0, 4'b0000, 4'b0000, 10'd0, 1'b0, 8'h00, 8'h3C};
        x_in[1*DW +: DW] = 8'h05;
        dp_result = 8'h3C;
        req = 4'b0010;
        for (int r = 0; r < 9; r++) begin
            cyc();
            check($sformatf("op_busy[%0d]", r), {31'd0, busy}, {31'd0, tbl[r].busy});
            check($sformatf("op_gnt[%0d]", r), {28'd0, gnt}, {28'd0, tbl[r].gnt});
            check($sformatf("op_ack[%0d]", r), {28'd0, ack}, {28'd0, tbl[r].ack});
            check($sformatf("op_ctrl[%0d]", r), {22'd0, ctrl}, {22'd0, tbl[r].ctrl});
            if (tbl[r].dpx_vld)
                check($sformatf("op_dpx[%0d]", r), {24'd0, dp_x}, {24'd0, tbl[r].dp_x});
            check($sformatf("op_result[%0d]", r), {24'd0, result}, {24'd0, tbl[r].result});
            if (r == 7) req = '0;
        end

        // req[2] dropped during S3: op still completes with an ack.
        dp_result = 8'h77;
        req = 4'b0100;
        for (int e = 0; e < 5; e++) cyc();
        check("drop_in_s3_ls", {31'd0, LS}, 32'd1);
        req = '0;
        cyc();
        cyc();
        cyc();
        check("drop_ack", {28'd0, ack}, 32'b0100);
        check("drop_result", {24'd0, result}, 32'h77);
        cyc();
        check("drop_idle_busy", {31'd0, busy}, 32'd0);
        check("drop_ack_pulse", {28'd0, ack}, 32'd0);

        // x_in[0] changed during S1 must not reach dp_x.
        x_in[0*DW +: DW] = 8'hA5;
        dp_result = 8'h5A;
        req = 4'b0001;
        for (int e = 0; e < 3; e++) cyc();
        check("xin_s1_lh", {31'd0, LH}, 32'd1);
        x_in[0*DW +: DW] = 8'hFF;
        for (int e = 0; e < 5; e++) cyc();
        check("xin_done_ack", {28'd0, ack}, 32'b0001);
        check("xin_done_dpx", {24'd0, dp_x}, 32'hA5);
        check("xin_done_result", {24'd0, result}, 32'h5A);
        req = '0;
        cyc();
        check("xin_idle_busy", {31'd0, busy}, 32'd0);

        // All four requesting: round-robin order, 8 cycles apart, no idle gap.
        do_reset();
        req = 4'b1111;
        ng = 0;
        nack = 0;
        gaps = 0;
        prev_gnt = '0;
        for (int c = 0; c < 60 && nack < 4; c++) begin
            cyc();
            if (gnt != '0 && prev_gnt == '0 && ng < 4) begin
                gseq[ng] = gnt;
                gcyc[ng] = c;
                ng++;
            end
            if (ng > 0 && !busy) gaps++;
            if (ack != '0) begin
                req = req & ~ack;
                nack++;
            end
            prev_gnt = gnt;
        end
        check("rr_grant_count", ng, 4);
        check("rr_ack_count", nack, 4);
        check("rr_idle_gaps", gaps, 0);
        for (int i = 0; i < 4; i++) begin
            if (i < ng) begin
                check($sformatf("rr_gnt[%0d]", i), {28'd0, gseq[i]}, 32'd1 << i);
                if (i > 0) check($sformatf("rr_spacing[%0d]", i), gcyc[i] - gcyc[i-1], 8);
            end
        end
        cyc();
        check("rr_end_idle", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
